// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// A started op runs for a fixed cycle count; HI/LO update on the edge busy falls.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr_en,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        o_dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;

    logic          w_start_ok;
    logic          w_load;
    logic          w_done;
    logic          w_mt_hi;
    logic          w_mt_lo;

    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [31:0]   w_div_b;
    logic [31:0]   w_uq;
    logic [31:0]   w_ur;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic [31:0]   w_mq;
    logic [31:0]   w_mr;
    logic [31:0]   w_sq;
    logic [31:0]   w_sr;
    logic [31:0]   w_res_hi;
    logic [31:0]   w_res_lo;
    logic          w_res_we;

    assign w_start_ok  = start && !op[2];
    assign busy        = (r_state == S_RUN);
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_mt_hi      = 1'b0;
        w_mt_lo      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end else if (wr_en && !start) begin
                    w_mt_hi = (op == 3'd4);
                    w_mt_lo = (op == 3'd5);
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Divisor forced non-zero so the dividers never see zero; the result is discarded then.
    assign w_div_b = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_uq    = r_a / w_div_b;
    assign w_ur    = r_a % w_div_b;

    // Signed divide on magnitudes: 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    assign w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
    assign w_mq    = w_abs_a / w_abs_b;
    assign w_mr    = w_abs_a % w_abs_b;
    assign w_sq    = (r_a[31] ^ w_div_b[31]) ? (32'd0 - w_mq) : w_mq;
    assign w_sr    = r_a[31] ? (32'd0 - w_mr) : w_mr;

    always_comb begin
        w_res_hi = hi;
        w_res_lo = lo;
        w_res_we = 1'b1;
        case (r_op)
            2'd0: {w_res_hi, w_res_lo} = w_prod_s;
            2'd1: {w_res_hi, w_res_lo} = w_prod_u;
            2'd2: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_we = (r_b != 32'd0);
            end
            default: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_we = (r_b != 32'd0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_a   <= data1;
                r_b   <= data2;
                r_op  <= op[1:0];
                r_cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_done && w_res_we) begin
                hi <= w_res_hi;
                lo <= w_res_lo;
            end else begin
                if (w_mt_hi) hi <= data1;
                if (w_mt_lo) lo <= data1;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random traffic against a cycle-level
// model that computes results with 64-bit integer arithmetic.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        wr_en;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbg_state;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .wr_en(wr_en),
        .data1(data1), .data2(data2), .busy(busy), .hi(hi), .lo(lo),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    int          m_left;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_op   = 3'd0;
        m_a    = 32'd0;
        m_b    = 32'd0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
    endtask

    task automatic model_result();
        longint sa, sb, p, q, r;
        case (m_op)
            3'd0: begin
                sa = longint'($signed(m_a));
                sb = longint'($signed(m_b));
                p  = sa * sb;
                {m_hi, m_lo} = p;
            end
            3'd1: begin
                sa = longint'({32'd0, m_a});
                sb = longint'({32'd0, m_b});
                p  = sa * sb;
                {m_hi, m_lo} = p;
            end
            3'd2: if (m_b != 32'd0) begin
                sa   = longint'($signed(m_a));
                sb   = longint'($signed(m_b));
                q    = sa / sb;
                r    = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            default: if (m_b != 32'd0) begin
                m_lo = m_a / m_b;
                m_hi = m_a % m_b;
            end
        endcase
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) model_result();
        end else if (start && op < 3'd4) begin
            m_op   = op;
            m_a    = data1;
            m_b    = data2;
            m_left = (op >= 3'd2) ? DC : MC;
        end else if (wr_en && !start) begin
            if (op == 3'd4) m_hi = data1;
            else if (op == 3'd5) m_lo = data1;
        end
    endtask

    // driver: one clock cycle with the given inputs, then check all outputs
    task automatic cycle(input logic s, input logic [2:0] o, input logic w,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = s;
        op    = o;
        wr_en = w;
        data1 = a;
        data2 = b;
        model_edge();
        @(posedge clk);
        #1;
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd6, 1'b0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] corner[5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
        return $urandom;
    endfunction

    task automatic pop_check(input string tag, input logic [31:0] got);
        check(tag, got, exp_q.pop_front());
    endtask

    initial begin
        logic        s, w;
        logic [2:0]  o;

        reset = 1'b0;
        start = 1'b0;
        op    = 3'd6;
        wr_en = 1'b0;
        data1 = 32'd0;
        data2 = 32'd0;
        model_reset();
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // MULT / MULTU of -2 * 3
        cycle(1'b1, 3'd0, 1'b0, 32'hFFFF_FFFE, 32'd3);
        idle(MC);
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFA);
        pop_check("mult_hi", hi); pop_check("mult_lo", lo);
        cycle(1'b1, 3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3);
        idle(MC);
        exp_q.push_back(32'h0000_0002); exp_q.push_back(32'hFFFF_FFFA);
        pop_check("multu_hi", hi); pop_check("multu_lo", lo);

        // DIV -7/2 and DIVU 7/2
        cycle(1'b1, 3'd2, 1'b0, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFD);
        pop_check("div_hi", hi); pop_check("div_lo", lo);
        cycle(1'b1, 3'd3, 1'b0, 32'd7, 32'd2);
        idle(DC);
        exp_q.push_back(32'd1); exp_q.push_back(32'd3);
        pop_check("divu_hi", hi); pop_check("divu_lo", lo);

        // overflow corner
        cycle(1'b1, 3'd2, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        exp_q.push_back(32'd0); exp_q.push_back(32'h8000_0000);
        pop_check("divovf_hi", hi); pop_check("divovf_lo", lo);

        // divide by zero leaves HI/LO alone
        cycle(1'b0, 3'd4, 1'b1, 32'h11, 32'd0);
        cycle(1'b0, 3'd5, 1'b1, 32'h22, 32'd0);
        cycle(1'b1, 3'd2, 1'b0, 32'd99, 32'd0);
        idle(DC);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22);
        pop_check("div0_hi", hi); pop_check("div0_lo", lo);

        // start while busy uses original operands and timing
        cycle(1'b1, 3'd0, 1'b0, 32'd3, 32'd4);
        idle(1);
        cycle(1'b1, 3'd0, 1'b0, 32'd100, 32'd200);
        idle(MC - 3);
        check("swb_busy_hold", {31'd0, busy}, 32'd1);
        idle(1);
        exp_q.push_back(32'd0); exp_q.push_back(32'd12);
        pop_check("swb_hi", hi); pop_check("swb_lo", lo);
        check("swb_busy_fall", {31'd0, busy}, 32'd0);

        // MTHI, then start with wr_en high
        cycle(1'b0, 3'd4, 1'b1, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        cycle(1'b1, 3'd0, 1'b1, 32'd5, 32'd6);
        check("start_wins_hi", hi, 32'hDEAD_BEEF);
        check("start_wins_busy", {31'd0, busy}, 32'd1);
        idle(MC);

        // asynchronous reset in the middle of a DIV
        cycle(1'b1, 3'd2, 1'b0, 32'd100, 32'd7);
        idle(3);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 3'd3, 1'b0, 32'd100, 32'd7);
        idle(DC);
        exp_q.push_back(32'd2); exp_q.push_back(32'd14);
        pop_check("post_rst_hi", hi); pop_check("post_rst_lo", lo);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            o = 3'($urandom_range(0, 7));
            w = $urandom_range(0, 1);
            if (s && w && (o == 3'd4 || o == 3'd5)) w = 1'b0;
            cycle(s, o, w, pick_val(), pick_val());
        end
        idle(DC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
